ni_flit_injector: RTL and testbench

//  Credit-based flit transmitter on the PE side of a Node; it is the sender into router local input port 5 (in5/vi5).

---
 rtl/noc_flit_pkg.sv | 41 ++++
 rtl/noc_credit_counter.sv | 42 ++++
 rtl/ni_flit_injector.sv | 147 ++++++++++++++
 tb/tb_ni_flit_injector.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_flit_pkg.sv
// Shared flit definitions for the NoC link: width, type codes, field positions and FSM states.
package noc_flit_pkg;

  localparam int FW = 20;
  localparam int PW = 18;

  localparam logic [1:0] FLIT_HEAD   = 2'b00;
  localparam logic [1:0] FLIT_BODY   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  localparam int TYPE_MSB = 19;
  localparam int TYPE_LSB = 18;
  localparam int DEST_MSB = 17;
  localparam int DEST_LSB = 14;
  localparam int SRC_MSB  = 13;
  localparam int SRC_LSB  = 10;
  localparam int LEN_MSB  = 9;
  localparam int LEN_LSB  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } inj_state_t;

  // Head flit: type, dest, src, len; low six bits are reserved and always zero.
  function automatic logic [FW-1:0] make_head(input logic [1:0] ftype,
                                              input logic [3:0] dest,
                                              input logic [3:0] src,
                                              input logic [3:0] len);
    logic [FW-1:0] f;
    f = '0;
    f[TYPE_MSB:TYPE_LSB] = ftype;
    f[DEST_MSB:DEST_LSB] = dest;
    f[SRC_MSB:SRC_LSB]   = src;
    f[LEN_MSB:LEN_LSB]   = len;
    return f;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Saturating credit counter: starts full, +1 per returned credit, -1 per sent flit.
// A credit returned while already full is dropped and flagged in a sticky error bit.
module noc_credit_counter #(
  parameter int CREDITS = 4,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic          o_err
);

  localparam logic [CW-1:0] MAX_COUNT = CW'(CREDITS);

  logic [CW-1:0] r_count;
  logic          r_err;

  // Count update; simultaneous inc and dec cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= MAX_COUNT;
      r_err   <= 1'b0;
    end else begin
      case ({i_inc, i_dec})
        2'b10: begin
          if (r_count == MAX_COUNT) r_err <= 1'b1;
          else                      r_count <= r_count + 1'b1;
        end
        2'b01: begin
          if (r_count != '0) r_count <= r_count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_err   = r_err;

endmodule

// File: rtl/ni_flit_injector.sv
// PE-side flit injector: turns packet requests plus payload words into head/body/tail
// flits on a credit-controlled link, at most one flit per cycle, output registered.
module ni_flit_injector
  import noc_flit_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic [3:0]                   position,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [3:0]                   req_dest,
  input  logic [3:0]                   req_len,
  input  logic                         pl_valid,
  output logic                         pl_ready,
  input  logic [PW-1:0]                pl_data,
  output logic [FW-1:0]                o,
  output logic                         vo,
  input  logic                         ci,
  output logic                         busy,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
  output logic                         credit_err
);

  localparam int CW = $clog2(CREDITS + 1);

  inj_state_t    r_state;
  inj_state_t    w_state_next;
  logic [3:0]    r_dest;
  logic [3:0]    r_len;
  logic [3:0]    r_src;
  logic [3:0]    r_remaining;
  logic [FW-1:0] r_o;
  logic          r_vo;

  logic          w_emit;
  logic          w_req_fire;
  logic [FW-1:0] w_flit;
  logic [CW-1:0] w_count;
  logic          w_credit_ok;

  noc_credit_counter #(
    .CREDITS (CREDITS),
    .CW      (CW)
  ) u_credits (
    .clk     (clk),
    .rst     (RST),
    .i_inc   (ci),
    .i_dec   (w_emit),
    .o_count (w_count),
    .o_err   (credit_err)
  );

  // Only the registered count gates sending; a same-cycle credit return does not help.
  assign w_credit_ok = (w_count != '0);

  // Next state, handshakes and the flit to emit this cycle.
  always_comb begin
    w_state_next = r_state;
    w_emit       = 1'b0;
    w_req_fire   = 1'b0;
    w_flit       = '0;
    req_ready    = 1'b0;
    pl_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_req_fire   = 1'b1;
          w_state_next = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (w_credit_ok) begin
          w_emit = 1'b1;
          if (r_len == 4'd0) begin
            w_flit       = make_head(FLIT_SINGLE, r_dest, r_src, r_len);
            w_state_next = ST_IDLE;
          end else begin
            w_flit       = make_head(FLIT_HEAD, r_dest, r_src, r_len);
            w_state_next = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        pl_ready = w_credit_ok;
        if (pl_valid && w_credit_ok) begin
          w_emit = 1'b1;
          if (r_remaining == 4'd1) begin
            w_flit       = {FLIT_TAIL, pl_data};
            w_state_next = ST_IDLE;
          end else begin
            w_flit = {FLIT_BODY, pl_data};
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Capture the request fields (including our own id) at acceptance.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_dest <= '0;
      r_len  <= '0;
      r_src  <= '0;
    end else if (w_req_fire) begin
      r_dest <= req_dest;
      r_len  <= req_len;
      r_src  <= position;
    end
  end

  // Payload flits still owed: loaded when the head goes out, decremented per body/tail.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_remaining <= '0;
    end else if (w_emit) begin
      if (r_state == ST_HEAD) r_remaining <= r_len;
      else                    r_remaining <= r_remaining - 4'd1;
    end
  end

  // Link output register: valid pulses for one cycle, data holds its last value.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_o  <= '0;
      r_vo <= 1'b0;
    end else begin
      r_vo <= w_emit;
      if (w_emit) r_o <= w_flit;
    end
  end

  assign o          = r_o;
  assign vo         = r_vo;
  assign busy       = (r_state != ST_IDLE);
  assign credit_cnt = w_count;

endmodule

// File: tb/tb_ni_flit_injector.sv
// Scoreboard bench for ni_flit_injector: stimulus pushes expected flits, a negedge monitor pops on vo.
module tb_ni_flit_injector;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  position = 4'd12;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_dest = '0;
  logic [3:0]  req_len = '0;
  logic        pl_valid = 1'b0;
  logic        pl_ready;
  logic [17:0] pl_data = '0;
  logic [19:0] o;
  logic        vo;
  logic        ci = 1'b0;
  logic        busy;
  logic [2:0]  credit_cnt;
  logic        credit_err;

  int checks = 0;
  int failures = 0;
  int vo_count = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  ni_flit_injector #(.CREDITS(4)) dut (
    .clk        (clk),
    .RST        (RST),
    .position   (position),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dest   (req_dest),
    .req_len    (req_len),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .pl_data    (pl_data),
    .o          (o),
    .vo         (vo),
    .ci         (ci),
    .busy       (busy),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
  );

  // Monitor: every flit on the link is compared against the head of the expected queue.
  always @(negedge clk) begin
    if (!RST && vo) begin
      vo_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL flit_unexpected got=%h required=none", o);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL flit got=%h required=%h", o, e);
        end else begin
          $display("flit ok o=%h", o);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end else begin
      $display("check ok %s = %0h", name, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [3:0] dest, input logic [3:0] len);
    int n;
    req_valid = 1'b1;
    req_dest  = dest;
    req_len   = len;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (!req_ready) check("req_timeout", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic send_pl(input logic [17:0] d);
    int n;
    pl_valid = 1'b1;
    pl_data  = d;
    n = 0;
    while (!pl_ready && n < 50) begin tick(); n++; end
    if (!pl_ready) check("pl_timeout", 32'(pl_ready), 32'd1);
    tick();
    pl_valid = 1'b0;
  endtask

  task automatic pulse_ci();
    ci = 1'b1;
    tick();
    ci = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || vo || exp_q.size() != 0) && n < 100) begin tick(); n++; end
    if (busy || vo || exp_q.size() != 0) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int c0;
    // Reset state
    tick(); tick();
    check("rst_o", 32'(o), 32'h0);
    check("rst_vo", 32'(vo), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_pl_ready", 32'(pl_ready), 32'd0);
    check("rst_credit", 32'(credit_cnt), 32'd4);
    check("rst_err", 32'(credit_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    RST = 1'b0;
    tick();

    // 1: dest 5, len 2, src 12
    exp_q.push_back(20'h17080);
    exp_q.push_back(20'h52345);
    exp_q.push_back(20'h800AA);
    send_req(4'd5, 4'd2);
    check("t1_busy", 32'(busy), 32'd1);
    send_pl(18'h12345);
    send_pl(18'h000AA);
    wait_idle();
    check("t1_credit", 32'(credit_cnt), 32'd1);
    repeat (3) pulse_ci();
    check("t1_credit_back", 32'(credit_cnt), 32'd4);

    // 2: single head+tail flit
    c0 = vo_count;
    exp_q.push_back(20'hCF000);
    send_req(4'd3, 4'd0);
    wait_idle();
    tick();
    check("t2_pulses", 32'(vo_count - c0), 32'd1);
    check("t2_idle", 32'(req_ready), 32'd1);
    pulse_ci();

    // 3: len 6 with no credit returns: 4 flits then stall
    c0 = vo_count;
    exp_q.push_back(20'h1F180);
    for (int i = 1; i <= 5; i++) exp_q.push_back(20'h40000 | 20'(i));
    exp_q.push_back(20'h80006);
    send_req(4'd7, 4'd6);
    send_pl(18'd1);
    send_pl(18'd2);
    send_pl(18'd3);
    pl_valid = 1'b1;
    pl_data  = 18'd4;
    repeat (5) tick();
    check("t3_stall_pl_ready", 32'(pl_ready), 32'd0);
    check("t3_stall_vo", 32'(vo), 32'd0);
    check("t3_stall_credit", 32'(credit_cnt), 32'd0);
    check("t3_four_flits", 32'(vo_count - c0), 32'd4);
    pulse_ci();
    tick();
    pl_valid = 1'b0;
    repeat (4) tick();
    check("t3_one_more", 32'(vo_count - c0), 32'd5);
    check("t3_stall_again", 32'(pl_ready), 32'd0);
    pulse_ci();
    send_pl(18'd5);
    pulse_ci();
    send_pl(18'd6);
    wait_idle();
    repeat (4) pulse_ci();
    check("t3_credit_back", 32'(credit_cnt), 32'd4);

    // 4: emit and credit return in the same cycle, then overflow
    exp_q.push_back(20'h070C0);
    exp_q.push_back(20'h40011);
    exp_q.push_back(20'h40022);
    exp_q.push_back(20'h80033);
    send_req(4'd1, 4'd3);
    send_pl(18'h11);
    check("t4_credit_pre", 32'(credit_cnt), 32'd2);
    pl_valid = 1'b1;
    pl_data  = 18'h22;
    ci       = 1'b1;
    tick();
    ci       = 1'b0;
    pl_valid = 1'b0;
    check("t4_credit_same", 32'(credit_cnt), 32'd2);
    send_pl(18'h33);
    wait_idle();
    repeat (3) pulse_ci();
    check("t4_credit_full", 32'(credit_cnt), 32'd4);
    check("t4_err_clear", 32'(credit_err), 32'd0);
    pulse_ci();
    check("t4_credit_sat", 32'(credit_cnt), 32'd4);
    check("t4_err_set", 32'(credit_err), 32'd1);

    // 5: three-cycle payload stall mid-packet
    exp_q.push_back(20'h270C0);
    exp_q.push_back(20'h40101);
    exp_q.push_back(20'h40202);
    exp_q.push_back(20'h80303);
    send_req(4'd9, 4'd3);
    send_pl(18'h101);
    c0 = vo_count;
    repeat (3) tick();
    check("t5_bubbles", 32'(vo_count - c0), 32'd1);
    check("t5_bubble_vo", 32'(vo), 32'd0);
    send_pl(18'h202);
    send_pl(18'h303);
    wait_idle();
    repeat (4) pulse_ci();

    // 6: async reset mid-packet
    exp_q.push_back(20'h0B140);
    exp_q.push_back(20'h40555);
    send_req(4'd2, 4'd5);
    send_pl(18'h555);
    tick();
    check("t6_busy_pre", 32'(busy), 32'd1);
    check("t6_credit_pre", 32'(credit_cnt), 32'd2);
    #3 RST = 1'b1;
    #1;
    check("t6_vo", 32'(vo), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_credit", 32'(credit_cnt), 32'd4);
    check("t6_err", 32'(credit_err), 32'd0);
    tick();
    RST = 1'b0;
    tick();
    exp_q.push_back(20'h13040);
    exp_q.push_back(20'h80777);
    send_req(4'd4, 4'd1);
    send_pl(18'h777);
    wait_idle();
    check("t6_credit_after", 32'(credit_cnt), 32'd2);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
